// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle fetch/execute sequencer for the 8-bit accumulator machine.
//   It owns the program counter and the instruction register. It shares the
//   single memory port between instruction fetch (PC address) and LW/SW data
//   access (accumulator address). It gates the decoder write enables so that
//   each instruction commits exactly once.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   run               fetch the next instruction when sampled at a boundary
//   mem_rdata         memory read data, valid while mem_ready=1
//   mem_ready         memory completes the current request this cycle
//   acc_q             accumulator: data address for LW/SW and branch target
//   brnch_in          decoder branch flag
//   cond_true         ALU "!= 0" result used by BNZ
//   reg_we_in         ungated decoder write enable
//   mem_we_in         ungated decoder write enable
//   acc_we_in         ungated decoder write enable
//   mem_req           memory request, held until mem_ready
//   mem_addr          pc during fetch, acc_q during a data access
//   sel_mem_in        0 = pc address, 1 = accumulator address
//   mem_we            gated memory write enable, only during a data access
//   reg_we, acc_we    gated one-cycle commit pulses
//   inst              instruction register
//   opcode            top three bits of inst, sent to the decoder
//   pc                program counter
//   retire            one-cycle pulse per completed instruction
module fetch_sequencer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] acc_q,
    input  logic              brnch_in,
    input  logic              cond_true,
    input  logic              reg_we_in,
    input  logic              mem_we_in,
    input  logic              acc_we_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              sel_mem_in,
    output logic              mem_we,
    output logic              reg_we,
    output logic              acc_we,
    output logic [DATA_W-1:0] inst,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic              retire
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM
    } seqStateT;

    seqStateT state;
    logic     memDone;
    logic     isMemOp;

    // Opcodes 110 (SW) and 111 (LW) share the two set top bits.
    assign isMemOp = (inst[DATA_W-1:DATA_W-2] == 2'b11);
    assign memDone = (state == MEM) && mem_ready;
    assign opcode  = inst[DATA_W-1:DATA_W-3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            inst  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    if (mem_ready) begin
                        inst  <= mem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state <= isMemOp ? MEM : EXEC;
                end
                EXEC: begin
                    // Branch target is acc_q as seen this cycle; a
                    // simultaneous accumulator write only lands afterwards.
                    if (brnch_in && cond_true) pc <= acc_q;
                    else                       pc <= pc + ADDR_W'(1);
                    state <= run ? FETCH : IDLE;
                end
                MEM: begin
                    if (mem_ready) begin
                        pc    <= pc + ADDR_W'(1);
                        state <= run ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit enables follow the decoder inputs in the same cycle, so they are
    // decoded from the registered state rather than registered themselves.
    // The asynchronous reset forces state to IDLE, which clears all of them
    // without waiting for a clock edge.
    always_comb begin
        mem_req    = (state == FETCH) || (state == MEM);
        sel_mem_in = (state == MEM);
        mem_addr   = (state == MEM) ? acc_q : pc;
        mem_we     = (state == MEM) && mem_we_in;
        reg_we     = ((state == EXEC) || memDone) && reg_we_in;
        acc_we     = (state == EXEC) && acc_we_in;
        retire     = (state == EXEC) || memDone;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// tb_fetch_sequencer
//   Scoreboard bench for fetch_sequencer. An instruction-level reference
//   model turns every issued instruction into an expected record. A driver
//   applies the decoder inputs for each instruction. A memory model answers
//   requests with programmable or random wait states. A monitor pops the
//   record at each retire and checks the bus activity in between.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic [7:0] mem_rdata;
    logic       mem_ready = 1'b0;
    logic [7:0] acc_q = 8'h00;
    logic       brnch_in = 1'b0, cond_true = 1'b0;
    logic       reg_we_in = 1'b0, mem_we_in = 1'b0, acc_we_in = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       sel_mem_in, mem_we, reg_we, acc_we;
    logic [7:0] inst;
    logic [2:0] opcode;
    logic [7:0] pc;
    logic       retire;

    fetch_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .acc_q(acc_q),
        .brnch_in(brnch_in), .cond_true(cond_true),
        .reg_we_in(reg_we_in), .mem_we_in(mem_we_in), .acc_we_in(acc_we_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .sel_mem_in(sel_mem_in),
        .mem_we(mem_we), .reg_we(reg_we), .acc_we(acc_we),
        .inst(inst), .opcode(opcode), .pc(pc), .retire(retire)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] acc;
        bit         brnch, cond, rwi, mwi, awi;
        int         fw, mw;      // wait cycles for fetch / data; <0 = random
    } paramT;

    typedef struct {
        logic [7:0] fetchAddr, inst, acc, nextPc;
        bit         isMem, regWe, accWe, memWe;
        int         cyc;         // expected cycles FETCH..retire; 0 = unknown
    } expT;

    paramT      paramQ[$];
    expT        expQ[$];
    logic [7:0] memImg [256];
    assign mem_rdata = memImg[mem_addr];

    logic [7:0] modelPc = 8'h00;
    int         issuedTotal = 0, drvRetired = 0;
    int         checks = 0, passes = 0;
    int         curFw = 0, curMw = 0;
    bit         needNext = 1'b1, runReq = 1'b1, noise = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    // Reference model: one call per instruction, in program order.
    task automatic issue(input logic [7:0] acc, input bit br, input bit cond,
                         input bit rwi, input bit mwi, input bit awi,
                         input int fw, input int mw);
        paramT p;
        expT   e;
        p = '{acc, br, cond, rwi, mwi, awi, fw, mw};
        e.fetchAddr = modelPc;
        e.inst      = memImg[modelPc];
        e.isMem     = (e.inst >= 8'hC0);            // opcodes 6 (SW) and 7 (LW)
        e.acc       = acc;
        e.regWe     = rwi;
        e.accWe     = !e.isMem && awi;
        e.memWe     = e.isMem && mwi;
        e.nextPc    = (!e.isMem && br && cond) ? acc : 8'(modelPc + 8'd1);
        e.cyc       = (fw >= 0 && mw >= 0) ? (fw + 1) + 1 + (e.isMem ? mw + 1 : 1) : 0;
        modelPc     = e.nextPc;
        paramQ.push_back(p);
        expQ.push_back(e);
        issuedTotal++;
    endtask

    // Decoder-input driver; run is held high only while work is outstanding.
    paramT drvP;
    always begin
        @(negedge clk);
        if (retire) begin
            drvRetired++;
            needNext = 1'b1;
        end
        run = runReq && (issuedTotal - drvRetired > 0);
        @(posedge clk);
        #1;
        if (needNext && paramQ.size() > 0) begin
            drvP      = paramQ.pop_front();
            acc_q     = drvP.acc;
            brnch_in  = drvP.brnch;
            cond_true = drvP.cond;
            reg_we_in = drvP.rwi;
            mem_we_in = drvP.mwi;
            acc_we_in = drvP.awi;
            curFw     = drvP.fw;
            curMw     = drvP.mw;
            needNext  = 1'b0;
        end
    end

    // Memory model with wait states chosen at the start of each request.
    bit memBusy = 1'b0;
    int waitLeft = 0, w = 0;
    always begin
        @(posedge clk);
        #2;
        if (mem_req) begin
            if (!memBusy) begin
                memBusy  = 1'b1;
                w        = sel_mem_in ? curMw : curFw;
                waitLeft = (w < 0) ? int'($urandom_range(0, 2)) : w;
            end
            if (waitLeft > 0) begin
                mem_ready = 1'b0;
                waitLeft--;
            end else begin
                mem_ready = 1'b1;
                memBusy   = 1'b0;
            end
        end else begin
            memBusy   = 1'b0;
            mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor / scoreboard.
    expT        monE;
    int         monCyc = 0;
    bit         pcPend = 1'b0;
    logic [7:0] pcExp = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            monCyc = 0;
            pcPend = 1'b0;
        end else begin
            if (pcPend) begin
                chk("pc after retire", pc, pcExp);
                pcPend = 1'b0;
            end
            if ((mem_req && !sel_mem_in) || monCyc > 0) monCyc++;
            if (mem_req && !sel_mem_in) begin
                if (expQ.size() == 0) chk("unexpected fetch", mem_req, 0);
                else chk("fetch addr", mem_addr, expQ[0].fetchAddr);
            end
            if (mem_req && sel_mem_in && expQ.size() > 0) begin
                chk("data phase kind", sel_mem_in, expQ[0].isMem);
                chk("data addr", mem_addr, expQ[0].acc);
                chk("mem_we in data phase", mem_we, expQ[0].memWe);
            end else begin
                chk("mem_we outside data phase", mem_we, 0);
            end
            if (retire) begin
                if (expQ.size() == 0) begin
                    chk("unexpected retire", retire, 0);
                end else begin
                    monE = expQ.pop_front();
                    chk("reg_we at retire", reg_we, monE.regWe);
                    chk("acc_we at retire", acc_we, monE.accWe);
                    chk("inst", inst, monE.inst);
                    chk("opcode", opcode, monE.inst[7:5]);
                    if (monE.cyc > 0) chk("instruction cycles", monCyc, monE.cyc);
                    pcPend = 1'b1;
                    pcExp  = monE.nextPc;
                end
                monCyc = 0;
            end else begin
                chk("no commit without retire", {reg_we, acc_we}, 0);
            end
        end
    end

    task automatic drain(input int limit);
        int n = 0;
        while (expQ.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain timeout", expQ.size(), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, " mem_req"}, mem_req, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " sel_mem_in"}, sel_mem_in, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " reg_we"}, reg_we, 0);
        chk({tag, " acc_we"}, acc_we, 0);
        chk({tag, " retire"}, retire, 0);
        chk({tag, " pc"}, pc, 0);
        chk({tag, " inst"}, inst, 0);
        chk({tag, " opcode"}, opcode, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) memImg[i] = 8'h40;
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD at 0 with zero-wait memory: fetch request the cycle after run.
        issue(8'h00, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle before first fetch", mem_req, 0);
        @(negedge clk);
        chk("first fetch req", mem_req, 1);
        chk("first fetch addr", mem_addr, 0);
        drain(50);

        // ADDs up to 0x05, LW with two data wait cycles, SW, branches, wrap.
        for (int i = 0; i < 4; i++) issue(8'h00, 0, 0, 1, 0, 1, 0, 0);
        memImg[8'h05] = 8'hE0;
        issue(8'h80, 0, 0, 1, 0, 0, 0, 2);
        memImg[8'h06] = 8'hC0;
        issue(8'h33, 0, 0, 0, 1, 1, 0, 1);
        memImg[8'h07] = 8'h80;
        issue(8'h20, 1, 1, 0, 0, 0, 0, 0);
        memImg[8'h20] = 8'h80;
        issue(8'h20, 1, 0, 0, 0, 0, 0, 0);
        memImg[8'h21] = 8'h80;
        issue(8'hFF, 1, 1, 0, 0, 0, 1, 0);
        memImg[8'hFF] = 8'h40;
        issue(8'h00, 0, 0, 1, 0, 1, 1, 0);
        drain(200);

        // run dropped during DECODE: the ADD still commits, then stays idle.
        memImg[8'h00] = 8'h40;
        memImg[8'h01] = 8'h40;
        issue(8'h00, 0, 0, 1, 0, 1, 0, 0);
        issue(8'h00, 0, 0, 1, 0, 0, 0, 0);
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        chk("fetch before run drop", mem_req, 1);
        @(posedge clk);
        #1 runReq = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!retire && n < 20);
        chk("retire after run drop", retire, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle while run low", mem_req, 0);
        end
        @(posedge clk);
        #1 runReq = 1'b1;
        drain(50);

        // Randomised program with random wait states and stray mem_ready.
        noise = 1'b1;
        for (int i = 0; i < 256; i++) memImg[i] = 8'($urandom);
        for (int i = 0; i < 60; i++)
            issue(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), -1, -1);
        drain(3000);
        noise = 1'b0;

        // Asynchronous reset while a fetch is waiting on memory.
        issue(8'h00, 0, 0, 1, 1, 1, 6, 0);
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        chk("fetch pending before reset", mem_req, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("async reset");
        paramQ.delete();
        expQ.delete();
        issuedTotal = drvRetired;
        needNext    = 1'b1;
        modelPc     = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("no pulse in reset", {reg_we, acc_we, mem_we, retire, mem_req}, 0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        memImg[8'h00] = 8'h40;
        issue(8'h00, 0, 0, 1, 0, 0, 0, 0);
        drain(50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch/execute sequencer for the 8-bit accumulator machine. It supplies instructions to the opcode decoder and arbitrates the single shared von Neumann memory between instruction fetch (PC address) and LW/SW data access (accumulator address). It owns the PC and instruction register, and gates the decoder's write enables so that state commits exactly once per instruction.

## Interface

- ADDR_W, 8, PC and memory address width
- DATA_W, 8, memory data and instruction width; opcode is inst[DATA_W-1:DATA_W-3]

- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  1 = fetch next instruction; 0 = stop at the next instruction boundary
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the current request this cycle
- acc_q  in  ADDR_W  accumulator value; data address for LW/SW and branch target
- brnch_in  in  1  decoder branch flag
- cond_true  in  1  ALU "!= 0" result for BNZ
- reg_we_in, mem_we_in, acc_we_in  in  1 each  ungated decoder write enables
- mem_req  out  1  memory request; held until mem_ready
- mem_addr  out  ADDR_W  PC in FETCH, acc_q in MEM
- sel_mem_in  out  1  0 = PC address, 1 = accumulator address
- mem_we  out  1  mem_we_in gated, asserted only in MEM
- reg_we, acc_we  out  1 each  gated enables, one-cycle commit pulse
- inst  out  DATA_W  instruction register
- opcode  out  3  inst[7:5], to decoder
- pc  out  ADDR_W  program counter
- retire  out  1  one-cycle pulse per completed instruction

## Operation

- States: IDLE, FETCH, DECODE, EXEC, MEM.
- IDLE: no request. Enter FETCH when run=1.
- FETCH: mem_req=1, mem_addr=pc, sel_mem_in=0. On mem_ready: inst<=mem_rdata and go to DECODE. Otherwise stay, with address held stable.
- DECODE: one settle cycle for the combinational decoder. No enables. For opcode 110/111 go to MEM, otherwise go to EXEC.
- EXEC: reg_we=reg_we_in, acc_we=acc_we_in, retire=1 for one cycle. mem_we is forced to 0.
  - If brnch_in && cond_true: pc<=acc_q. Otherwise pc<=pc+1.
  - Next state is FETCH if run=1, else IDLE.
- MEM: mem_req=1, mem_addr=acc_q, sel_mem_in=1, mem_we=mem_we_in (SW) for the whole request. On mem_ready:
  - reg_we=reg_we_in (LW captures mem_rdata in the register file that cycle).
  - retire=1, pc<=pc+1, next state as in EXEC.
  - reg_we is asserted only in the mem_ready cycle.
- Outside EXEC/MEM-completion, reg_we, acc_we and retire are 0. mem_we is 0 outside MEM.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 = 0x00. Branch to any value is permitted.
- run is sampled only at instruction boundaries (IDLE, EXEC exit, MEM completion). An instruction in flight always completes.

## Timing

- Reset (async, immediate): state=IDLE, pc=0, inst=0, opcode=0, mem_req=0, mem_addr=0, sel_mem_in=0, mem_we=0, reg_we=0, acc_we=0, retire=0.
- Reset during a pending request drops mem_req in the same cycle. No partial commit occurs.
- Zero-wait memory (mem_ready tied 1):
  - Non-memory instruction: 3 cycles (FETCH, DECODE, EXEC).
  - LW/SW: 3 cycles (FETCH, DECODE, MEM).
  - Each wait cycle on mem_ready adds one cycle in FETCH or MEM.
- First fetch request appears the cycle after run is sampled high in IDLE.
- mem_ready while mem_req=0 is ignored.
- Branch target is the acc_q value sampled in the EXEC cycle. An acc_we in the same cycle does not affect the target.

## Test plan

- Reset then run=1, memory holds 0x40 (ADD) at addr 0, mem_ready=1:
  - mem_req with addr 0x00 in cycle 1.
  - inst=0x40, opcode=010.
  - reg_we and retire pulse in cycle 3, then pc=0x01.
- LW (0xE0) at pc 0x05, acc_q=0x80, mem_ready low for 2 cycles in MEM:
  - mem_addr=0x80 and sel_mem_in=1 for 3 cycles.
  - reg_we only in the mem_ready cycle.
  - pc=0x06 afterwards.
- SW (0xC0), acc_q=0x33:
  - mem_we=1 for exactly the MEM request cycles.
  - reg_we=0 and acc_we=0 throughout.
- BNZ (0x80) with brnch_in=1, acc_q=0x20:
  - cond_true=1 gives pc=0x20.
  - cond_true=0 gives pc=pc+1.
  - pc=0xFF non-branch wraps to 0x00.
- run dropped during DECODE of an ADD:
  - EXEC still commits.
  - Sequencer enters IDLE with mem_req=0 until run returns.
- rst_n asserted mid-FETCH with mem_req=1:
  - All outputs reach reset values without a clock edge.
  - No reg_we, acc_we or mem_we pulse is emitted.
